// File: rtl/sb_spi_bus_arb.sv
// sb_spi_bus_arb: two-requester round-robin arbiter onto a strobe/ack system bus for the SPI hard IP.
// Ports: clk_i/rst_i clock and async reset; reqN_* request channel (valid, rw, addr, wdata, ready);
// rspN_* completion pulse with read data and timeout flag; sb_* bus strobe/direction/address/data/ack;
// busy_o high whenever a transaction is in flight.
module sb_spi_bus_arb #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int TIMEOUT_P = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_valid_i,
    input  logic              req0_rw_i,
    input  logic [ADDR_W-1:0] req0_addr_i,
    input  logic [DATA_W-1:0] req0_wdata_i,
    output logic              req0_ready_o,
    input  logic              req1_valid_i,
    input  logic              req1_rw_i,
    input  logic [ADDR_W-1:0] req1_addr_i,
    input  logic [DATA_W-1:0] req1_wdata_i,
    output logic              req1_ready_o,
    output logic              rsp0_valid_o,
    output logic [DATA_W-1:0] rsp0_rdata_o,
    output logic              rsp0_err_o,
    output logic              rsp1_valid_o,
    output logic [DATA_W-1:0] rsp1_rdata_o,
    output logic              rsp1_err_o,
    output logic              sb_stb_o,
    output logic              sb_rw_o,
    output logic [ADDR_W-1:0] sb_adr_o,
    output logic [DATA_W-1:0] sb_dat_o,
    input  logic [DATA_W-1:0] sb_dat_i,
    input  logic              sb_ack_i,
    output logic              busy_o
);
    localparam int CW = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_P - 1);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t            state, state_n;
    logic              gnt;
    logic [CW-1:0]     cnt;
    logic              g1, accept, done, sel_rw;
    logic [DATA_W-1:0] cap;

    // gnt doubles as the round-robin pointer: it holds the last granted index
    assign g1           = req1_valid_i && (!req0_valid_i || !gnt);
    assign accept       = (state == IDLE) && (req0_valid_i || req1_valid_i);
    assign req0_ready_o = accept && !g1;
    assign req1_ready_o = accept && g1;
    assign sel_rw       = g1 ? req1_rw_i : req0_rw_i;
    // ack beats timeout when both land in the same cycle
    assign done         = (state == BUS) && (sb_ack_i || cnt == TMAX);
    assign cap          = (sb_ack_i && !sb_rw_o) ? sb_dat_i : '0;

    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (accept ? BUS : IDLE) :
                  (state == BUS)  ? (done ? RESP : BUS)   : IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            gnt          <= 1'b1;
            cnt          <= '0;
            busy_o       <= 1'b0;
            sb_stb_o     <= 1'b0;
            sb_rw_o      <= 1'b0;
            sb_adr_o     <= '0;
            sb_dat_o     <= '0;
            rsp0_valid_o <= 1'b0;
            rsp0_rdata_o <= '0;
            rsp0_err_o   <= 1'b0;
            rsp1_valid_o <= 1'b0;
            rsp1_rdata_o <= '0;
            rsp1_err_o   <= 1'b0;
        end else begin
            state        <= state_n;
            busy_o       <= state_n != IDLE;
            rsp0_valid_o <= 1'b0;
            rsp1_valid_o <= 1'b0;
            if (accept) begin
                gnt      <= g1;
                cnt      <= '0;
                sb_stb_o <= 1'b1;
                sb_rw_o  <= sel_rw;
                sb_adr_o <= g1 ? req1_addr_i : req0_addr_i;
                sb_dat_o <= sel_rw ? (g1 ? req1_wdata_i : req0_wdata_i) : '0;
            end
            if (state == BUS && !sb_ack_i)
                cnt <= cnt + 1'b1;
            if (done) begin
                sb_stb_o <= 1'b0;
                if (gnt) begin
                    rsp1_valid_o <= 1'b1;
                    rsp1_rdata_o <= cap;
                    rsp1_err_o   <= !sb_ack_i;
                end else begin
                    rsp0_valid_o <= 1'b1;
                    rsp0_rdata_o <= cap;
                    rsp0_err_o   <= !sb_ack_i;
                end
            end
        end
    end
endmodule

// File: tb/tb_sb_spi_bus_arb.sv
// tb_sb_spi_bus_arb: directed table-driven bench for sb_spi_bus_arb plus reset/contention sequences.
module tb_sb_spi_bus_arb;
    logic       clk_i = 1'b0, rst_i = 1'b1;
    logic       req0_valid_i = 0, req0_rw_i = 0, req1_valid_i = 0, req1_rw_i = 0;
    logic [7:0] req0_addr_i = 0, req0_wdata_i = 0, req1_addr_i = 0, req1_wdata_i = 0;
    logic       req0_ready_o, req1_ready_o;
    logic       rsp0_valid_o, rsp0_err_o, rsp1_valid_o, rsp1_err_o;
    logic [7:0] rsp0_rdata_o, rsp1_rdata_o;
    logic       sb_stb_o, sb_rw_o, sb_ack_i = 0, busy_o;
    logic [7:0] sb_adr_o, sb_dat_o, sb_dat_i = 0;

    int checks = 0, failures = 0;

    sb_spi_bus_arb #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_P(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req0_valid_i(req0_valid_i), .req0_rw_i(req0_rw_i), .req0_addr_i(req0_addr_i),
        .req0_wdata_i(req0_wdata_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_rw_i(req1_rw_i), .req1_addr_i(req1_addr_i),
        .req1_wdata_i(req1_wdata_i), .req1_ready_o(req1_ready_o),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_rdata_o(rsp0_rdata_o), .rsp0_err_o(rsp0_err_o),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_rdata_o(rsp1_rdata_o), .rsp1_err_o(rsp1_err_o),
        .sb_stb_o(sb_stb_o), .sb_rw_o(sb_rw_o), .sb_adr_o(sb_adr_o), .sb_dat_o(sb_dat_o),
        .sb_dat_i(sb_dat_i), .sb_ack_i(sb_ack_i), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       v0, v1;
        logic       rw0;
        logic [7:0] a0, d0;
        logic       rw1;
        logic [7:0] a1, d1;
        int         ack_at;
        logic [7:0] sdat;
        logic       g;
        int         stb_n;
        logic [7:0] rd;
        logic       er;
    } vec_t;

    vec_t       vecs[7];
    vec_t       t;
    logic       erw;
    logic [7:0] ead, edt, grd;
    int         k;

    initial begin
        vecs[0] = '{1, 0, 0, 8'h08, 8'h00, 0, 8'h00, 8'h00,  2, 8'h5A, 0,  2, 8'h5A, 0};
        vecs[1] = '{0, 1, 0, 8'h00, 8'h00, 1, 8'h09, 8'hC3,  1, 8'hBB, 1,  1, 8'h00, 0};
        vecs[2] = '{1, 1, 1, 8'h20, 8'h11, 0, 8'h21, 8'h99,  1, 8'h44, 0,  1, 8'h00, 0};
        vecs[3] = '{1, 1, 1, 8'h30, 8'h12, 0, 8'h31, 8'h98,  3, 8'hA5, 1,  3, 8'hA5, 0};
        vecs[4] = '{1, 0, 0, 8'h40, 8'h00, 0, 8'h00, 8'h00,  0, 8'h66, 0, 16, 8'h00, 1};
        vecs[5] = '{0, 1, 0, 8'h00, 8'h00, 0, 8'h41, 8'h00, 16, 8'h77, 1, 16, 8'h77, 0};
        vecs[6] = '{1, 0, 1, 8'hFF, 8'h3C, 0, 8'h00, 8'h00, 16, 8'h55, 0, 16, 8'h00, 0};

        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_stb", sb_stb_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_rsp0_valid", rsp0_valid_o, 0);
        chk("rst_rsp1_valid", rsp1_valid_o, 0);
        chk("rst_adr", sb_adr_o, 0);
        chk("rst_rdata0", rsp0_rdata_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle_ready0", req0_ready_o, 0);
        chk("idle_ready1", req1_ready_o, 0);

        for (int i = 0; i < 7; i++) begin
            t = vecs[i];
            erw = t.g ? t.rw1 : t.rw0;
            ead = t.g ? t.a1 : t.a0;
            edt = erw ? (t.g ? t.d1 : t.d0) : 8'h00;
            req0_valid_i = t.v0; req0_rw_i = t.rw0; req0_addr_i = t.a0; req0_wdata_i = t.d0;
            req1_valid_i = t.v1; req1_rw_i = t.rw1; req1_addr_i = t.a1; req1_wdata_i = t.d1;
            #1;
            chk($sformatf("v%0d_ready0", i), req0_ready_o, !t.g);
            chk($sformatf("v%0d_ready1", i), req1_ready_o, t.g);
            chk($sformatf("v%0d_idle_busy", i), busy_o, 0);
            @(negedge clk_i);
            k = 0;
            do begin
                k++;
                chk($sformatf("v%0d_stb", i), sb_stb_o, 1);
                chk($sformatf("v%0d_rw", i), sb_rw_o, erw);
                chk($sformatf("v%0d_adr", i), sb_adr_o, ead);
                chk($sformatf("v%0d_dat", i), sb_dat_o, edt);
                chk($sformatf("v%0d_bus_ready", i), req0_ready_o | req1_ready_o, 0);
                chk($sformatf("v%0d_bus_busy", i), busy_o, 1);
                sb_ack_i = (k == t.ack_at);
                sb_dat_i = (k == t.ack_at) ? t.sdat : 8'hEE;
                @(negedge clk_i);
                sb_ack_i = 1'b0;
            end while (sb_stb_o && k < 40);
            chk($sformatf("v%0d_stb_cycles", i), k, t.stb_n);
            req0_valid_i = 0;
            req1_valid_i = 0;
            grd = t.g ? rsp1_rdata_o : rsp0_rdata_o;
            chk($sformatf("v%0d_rsp0_valid", i), rsp0_valid_o, !t.g);
            chk($sformatf("v%0d_rsp1_valid", i), rsp1_valid_o, t.g);
            chk($sformatf("v%0d_rdata", i), grd, t.rd);
            chk($sformatf("v%0d_err", i), t.g ? rsp1_err_o : rsp0_err_o, t.er);
            chk($sformatf("v%0d_resp_stb", i), sb_stb_o, 0);
            chk($sformatf("v%0d_resp_busy", i), busy_o, 1);
            @(negedge clk_i);
            chk($sformatf("v%0d_post_valid", i), rsp0_valid_o | rsp1_valid_o, 0);
            chk($sformatf("v%0d_post_busy", i), busy_o, 0);
            chk($sformatf("v%0d_rdata_hold", i), t.g ? rsp1_rdata_o : rsp0_rdata_o, t.rd);
            chk($sformatf("v%0d_err_hold", i), t.g ? rsp1_err_o : rsp0_err_o, t.er);
        end

        // abort a requester-0 read on its third strobe cycle
        req0_valid_i = 1; req0_rw_i = 0; req0_addr_i = 8'h50;
        #1;
        chk("abort_ready0", req0_ready_o, 1);
        @(negedge clk_i);
        req0_valid_i = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("abort_stb_pre", sb_stb_o, 1);
        rst_i = 1'b1;
        #1;
        chk("abort_stb", sb_stb_o, 0);
        chk("abort_busy", busy_o, 0);
        chk("abort_rsp0_valid", rsp0_valid_o, 0);
        chk("abort_rdata1", rsp1_rdata_o, 0);
        chk("abort_err0", rsp0_err_o, 0);
        chk("abort_adr", sb_adr_o, 0);
        @(negedge clk_i);
        rst_i = 1'b0;
        req0_valid_i = 1; req1_valid_i = 1;
        #1;
        chk("abort_regrant0", req0_ready_o, 1);
        chk("abort_regrant1", req1_ready_o, 0);
        req0_valid_i = 0; req1_valid_i = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            chk("abort_no_rsp", rsp0_valid_o | rsp1_valid_o, 0);
        end

        // continuous contention from reset with ack held high the whole time
        rst_i = 1'b1;
        req0_valid_i = 1; req0_rw_i = 1; req0_addr_i = 8'h60; req0_wdata_i = 8'h01;
        req1_valid_i = 1; req1_rw_i = 0; req1_addr_i = 8'h61;
        sb_ack_i = 1'b1; sb_dat_i = 8'h3E;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk($sformatf("rr%0d_ready0", c), req0_ready_o, (c % 6) == 0);
            chk($sformatf("rr%0d_ready1", c), req1_ready_o, (c % 6) == 3);
            chk($sformatf("rr%0d_stb", c), sb_stb_o, (c % 3) == 1);
            chk($sformatf("rr%0d_rsp0", c), rsp0_valid_o, (c % 6) == 2);
            chk($sformatf("rr%0d_rsp1", c), rsp1_valid_o, (c % 6) == 5);
            if (c % 6 == 4) chk($sformatf("rr%0d_adr", c), sb_adr_o, 8'h61);
            if (c % 6 == 5) chk($sformatf("rr%0d_rdata1", c), rsp1_rdata_o, 8'h3E);
            @(negedge clk_i);
        end
        sb_ack_i = 0; req0_valid_i = 0; req1_valid_i = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
